// File: rtl/rv32i_pkg.sv
// Shared encodings for the memory/writeback stage: writeback source select,
// load size codes and the stage FSM state type.
package rv32i_pkg;

    // Writeback source select
    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;
    localparam logic [1:0] WB_IMM = 2'b11;

    // Load size codes (funct3)
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Stage FSM: either free to accept, or parked waiting on a load response
    typedef enum logic {
        ST_IDLE      = 1'b0,
        ST_LOAD_WAIT = 1'b1
    } wb_state_e;

    // Sign- or zero-extend a byte/halfword to 32 bits
    function automatic logic [31:0] ext8(input logic [7:0] v, input logic sgn);
        return {{24{sgn & v[7]}}, v};
    endfunction

    function automatic logic [31:0] ext16(input logic [15:0] v, input logic sgn);
        return {{16{sgn & v[15]}}, v};
    endfunction

endpackage

// File: rtl/load_align.sv
// Combinational load extraction: picks the addressed byte/halfword out of a
// word-aligned read, extends it, and flags misaligned or illegal load sizes.
module load_align
    import rv32i_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr,
    input  logic [31:0] rdata,
    output logic [31:0] data,
    output logic        misalign
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Lane selection then extension by load size
    always_comb begin
        byte_sel = rdata[{addr, 3'b000} +: 8];
        half_sel = addr[1] ? rdata[31:16] : rdata[15:0];
        data     = 32'h0;
        misalign = 1'b0;
        case (funct3)
            F3_LB:  data = ext8(byte_sel, 1'b1);
            F3_LBU: data = ext8(byte_sel, 1'b0);
            F3_LH: begin
                data     = ext16(half_sel, 1'b1);
                misalign = addr[0];
            end
            F3_LHU: begin
                data     = ext16(half_sel, 1'b0);
                misalign = addr[0];
            end
            F3_LW: begin
                data     = rdata;
                misalign = (addr != 2'b00);
            end
            default: misalign = 1'b1;   // 011/110/111 are not loads
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// Memory/writeback stage: registers ALU/PC+4/IMM results straight through,
// completes loads either in the accept cycle or after a bounded wait on the
// data-memory response, and mirrors the writeback port as a bypass port.
module mem_wb_stage
    import rv32i_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic        ex_reg_write,
    input  logic [4:0]  ex_rd,
    input  logic [1:0]  ex_wb_sel,
    input  logic [2:0]  ex_funct3,
    input  logic [31:0] ex_alu_result,
    input  logic [31:0] ex_pc4,
    input  logic [31:0] ex_imm,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output logic        wb_en,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        stall_o,
    output logic        fwd_en,
    output logic [4:0]  fwd_rd,
    output logic [31:0] fwd_data,
    output logic        misalign_o,
    output logic        load_err
);

    localparam int              CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    wb_state_e          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [4:0]         ld_rd_q, ld_rd_d;
    logic [2:0]         ld_f3_q, ld_f3_d;
    logic [1:0]         ld_addr_q, ld_addr_d;
    logic               ld_we_q, ld_we_d;

    logic               wb_en_q, wb_en_d;
    logic [4:0]         wb_rd_q, wb_rd_d;
    logic [31:0]        wb_data_q, wb_data_d;
    logic               misalign_q, misalign_d;
    logic               load_err_q, load_err_d;

    logic               accept;
    logic               is_mem;
    logic               ex_we;
    logic [2:0]         al_f3;
    logic [1:0]         al_addr;
    logic [31:0]        al_data;
    logic               al_misalign;
    logic [31:0]        ex_data;

    assign stall_o = (state_q == ST_LOAD_WAIT);
    assign accept  = ex_valid & ~stall_o;
    assign is_mem  = (ex_wb_sel == WB_MEM);
    assign ex_we   = ex_reg_write & (ex_rd != 5'd0);

    // While waiting, the aligner works from the captured load, else from EX/MEM
    assign al_f3   = stall_o ? ld_f3_q   : ex_funct3;
    assign al_addr = stall_o ? ld_addr_q : ex_alu_result[1:0];

    load_align u_load_align (
        .funct3   (al_f3),
        .addr     (al_addr),
        .rdata    (dmem_rdata),
        .data     (al_data),
        .misalign (al_misalign)
    );

    // Writeback source mux for instructions completing at accept
    always_comb begin
        case (ex_wb_sel)
            WB_ALU:  ex_data = ex_alu_result;
            WB_MEM:  ex_data = al_data;
            WB_PC4:  ex_data = ex_pc4;
            default: ex_data = ex_imm;
        endcase
    end

    // State register plus load-wait bookkeeping
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            ld_rd_q   <= 5'd0;
            ld_f3_q   <= 3'd0;
            ld_addr_q <= 2'd0;
            ld_we_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ld_rd_q   <= ld_rd_d;
            ld_f3_q   <= ld_f3_d;
            ld_addr_q <= ld_addr_d;
            ld_we_q   <= ld_we_d;
        end
    end

    // Next-state: park on an aligned load whose data is not yet back
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ld_rd_d   = ld_rd_q;
        ld_f3_d   = ld_f3_q;
        ld_addr_d = ld_addr_q;
        ld_we_d   = ld_we_q;
        case (state_q)
            ST_IDLE: begin
                if (accept && is_mem && !al_misalign && !dmem_rvalid) begin
                    state_d   = ST_LOAD_WAIT;
                    cnt_d     = '0;
                    ld_rd_d   = ex_rd;
                    ld_f3_d   = ex_funct3;
                    ld_addr_d = ex_alu_result[1:0];
                    ld_we_d   = ex_we;
                end
            end
            default: begin
                if (dmem_rvalid || (cnt_q == CNT_LAST)) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        endcase
    end

    // Output decode: what the writeback/bypass registers take at this edge
    always_comb begin
        wb_en_d    = 1'b0;
        wb_rd_d    = wb_rd_q;
        wb_data_d  = wb_data_q;
        misalign_d = 1'b0;
        load_err_d = load_err_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (is_mem && al_misalign) begin
                        misalign_d = 1'b1;
                    end else if (!is_mem || dmem_rvalid) begin
                        wb_en_d = ex_we;
                        if (ex_we) begin
                            wb_rd_d   = ex_rd;
                            wb_data_d = ex_data;
                        end
                    end
                end
            end
            default: begin
                if (dmem_rvalid) begin
                    wb_en_d = ld_we_q;
                    if (ld_we_q) begin
                        wb_rd_d   = ld_rd_q;
                        wb_data_d = al_data;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    // Response never arrived: retire the load with zero data
                    wb_en_d    = ld_we_q;
                    load_err_d = 1'b1;
                    if (ld_we_q) begin
                        wb_rd_d   = ld_rd_q;
                        wb_data_d = 32'h0;
                    end
                end
            end
        endcase
    end

    // Writeback and status registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            wb_en_q    <= 1'b0;
            wb_rd_q    <= 5'd0;
            wb_data_q  <= 32'h0;
            misalign_q <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            wb_en_q    <= wb_en_d;
            wb_rd_q    <= wb_rd_d;
            wb_data_q  <= wb_data_d;
            misalign_q <= misalign_d;
            load_err_q <= load_err_d;
        end
    end

    assign wb_en      = wb_en_q;
    assign wb_rd      = wb_rd_q;
    assign wb_data    = wb_data_q;
    assign fwd_en     = wb_en_q;
    assign fwd_rd     = wb_rd_q;
    assign fwd_data   = wb_data_q;
    assign misalign_o = misalign_q;
    assign load_err   = load_err_q;

endmodule
